// File: rtl/p405s_icu_pkg.sv
// Shared ICU definitions: fill-buffer state encoding, line geometry and word parity.
// Used by p405s_icu_fillbuf_rd and p405s_icu_fillbuf_word.
package p405s_icu_pkg;

    localparam int ICU_LINE_WORDS = 8;

    typedef logic [$clog2(ICU_LINE_WORDS)-1:0] word_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10
    } fill_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_par(input logic [0:31] data);
        return ^data;
    endfunction

endpackage

// File: rtl/p405s_icu_fillbuf_word.sv
// One line-fill word: data register, valid flag and (with P405S_ICU_FILLBUF_PARITY_EN)
// a parity bit computed on write with a live mismatch indication.
module p405s_icu_fillbuf_word
    import p405s_icu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        we,
    input  logic [0:31] wdata,
    output logic [0:31] data,
    output logic        valid
`ifdef P405S_ICU_FILLBUF_PARITY_EN
    ,
    output logic        par_err
`endif
);

    logic [0:31] data_r;
    logic        valid_r;

    // Word storage; a fill start only drops validity, the old data is simply overwritten later.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (clr) begin
            data_r  <= data_r;
            valid_r <= 1'b0;
        end else if (we) begin
            data_r  <= wdata;
            valid_r <= 1'b1;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

`ifdef P405S_ICU_FILLBUF_PARITY_EN
    logic par_r;

    // Parity bit captured alongside the data word.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_r <= 1'b0;
        end else if (we && !clr) begin
            par_r <= even_par(wdata);
        end else begin
            par_r <= par_r;
        end
    end

    assign par_err = (even_par(data_r) != par_r);
`endif

    assign data  = data_r;
    assign valid = valid_r;

endmodule

// File: rtl/p405s_icu_fillbuf_rd.sv
// ICU line-fill buffer read/drain side: captures PLB words, serves fetch reads with
// same-cycle bypass, then drains the full line to the I-cache array. Optional macro:
// P405S_ICU_FILLBUF_PARITY_EN adds per-word parity and the rdParErr/arrParErr outputs.
module p405s_icu_fillbuf_rd
    import p405s_icu_pkg::*;
#(
    parameter int WORDS = ICU_LINE_WORDS,
    parameter int IDXW  = 3
) (
    input  logic            CB,
    input  logic            reset,
    input  logic            fillStart,
    input  logic            wrVal,
    input  logic [IDXW-1:0] wrIdx,
    input  logic [0:31]     wrData,
    input  logic            rdReq,
    input  logic [IDXW-1:0] rdIdx,
    output logic            rdVal,
    output logic [0:31]     rdData,
    output logic            arrWrVal,
    output logic [IDXW-1:0] arrWrIdx,
    output logic [0:31]     arrWrData,
    input  logic            arrWrAck,
    output logic            fillBusy,
    output logic            lineDone
`ifdef P405S_ICU_FILLBUF_PARITY_EN
    ,
    output logic            rdParErr,
    output logic            arrParErr
`endif
);

    fill_state_t     state_r, state_next_s;
    logic [IDXW-1:0] ptr_r, ptr_next_s;
    logic            clr_s, line_done_s, all_valid_s, wr_en_s;
    logic [WORDS-1:0] valid_s, wr_hit_s;
    logic [0:31]     word_data_s [WORDS];

    logic            rd_bypass_s, rd_stored_s, rd_hit_s;
    logic [0:31]     rd_data_next_s, arr_data_next_s;

    logic            rd_val_r, arr_wr_val_r, fill_busy_r, line_done_r;
    logic [0:31]     rd_data_r, arr_wr_data_r;
    logic [IDXW-1:0] arr_wr_idx_r;

`ifdef P405S_ICU_FILLBUF_PARITY_EN
    logic [WORDS-1:0] par_err_s;
    logic             rd_par_err_next_s, arr_par_err_next_s;
    logic             rd_par_err_r, arr_par_err_r;
`endif

    assign wr_en_s = wrVal && (state_r == FILL);

    for (genvar i = 0; i < WORDS; i++) begin : g_word
        assign wr_hit_s[i] = wr_en_s && (wrIdx == IDXW'(i));

        p405s_icu_fillbuf_word u_word (
            .clk     (CB),
            .reset   (reset),
            .clr     (clr_s),
            .we      (wr_hit_s[i]),
            .wdata   (wrData),
            .data    (word_data_s[i]),
            .valid   (valid_s[i])
`ifdef P405S_ICU_FILLBUF_PARITY_EN
            ,
            .par_err (par_err_s[i])
`endif
        );
    end

    // The word landing this cycle counts towards a complete line.
    assign all_valid_s = &(valid_s | wr_hit_s);

    // Fill/drain sequencing and drain pointer advance.
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        clr_s        = 1'b0;
        line_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (fillStart) begin
                    state_next_s = FILL;
                    clr_s        = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FILL: begin
                if (all_valid_s) begin
                    state_next_s = DRAIN;
                    ptr_next_s   = {IDXW{1'b0}};
                end else begin
                    state_next_s = FILL;
                end
            end
            DRAIN: begin
                if (arrWrAck) begin
                    ptr_next_s = ptr_r + IDXW'(1);
                    if (ptr_r == IDXW'(WORDS - 1)) begin
                        state_next_s = IDLE;
                        line_done_s  = 1'b1;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
                ptr_next_s   = {IDXW{1'b0}};
            end
        endcase
    end

    // Next array word; forward the final fill write, which is not yet in storage.
    always_comb begin
        arr_data_next_s = word_data_s[ptr_next_s];
        if (wr_hit_s[ptr_next_s]) begin
            arr_data_next_s = wrData;
        end else begin
            arr_data_next_s = word_data_s[ptr_next_s];
        end
    end

    // Fetch read lookup; a fill start in the same cycle invalidates stored words first.
    always_comb begin
        rd_bypass_s    = rdReq && wr_hit_s[rdIdx];
        rd_stored_s    = rdReq && valid_s[rdIdx] && !clr_s;
        rd_hit_s       = rd_bypass_s || rd_stored_s;
        rd_data_next_s = word_data_s[rdIdx];
        if (rd_bypass_s) begin
            rd_data_next_s = wrData;
        end else begin
            rd_data_next_s = word_data_s[rdIdx];
        end
    end

`ifdef P405S_ICU_FILLBUF_PARITY_EN
    assign rd_par_err_next_s  = rd_stored_s && !rd_bypass_s && par_err_s[rdIdx];
    assign arr_par_err_next_s = (state_next_s == DRAIN) && !wr_hit_s[ptr_next_s]
                                && par_err_s[ptr_next_s];

    // Registered parity error flags, aligned with rdVal and arrWrVal.
    always_ff @(posedge CB) begin
        if (reset) begin
            rd_par_err_r  <= 1'b0;
            arr_par_err_r <= 1'b0;
        end else begin
            rd_par_err_r  <= rd_par_err_next_s;
            arr_par_err_r <= arr_par_err_next_s;
        end
    end

    assign rdParErr  = rd_par_err_r;
    assign arrParErr = arr_par_err_r;
`endif

    // State, pointer and all registered outputs.
    always_ff @(posedge CB) begin
        if (reset) begin
            state_r       <= IDLE;
            ptr_r         <= {IDXW{1'b0}};
            rd_val_r      <= 1'b0;
            rd_data_r     <= 32'h0000_0000;
            arr_wr_val_r  <= 1'b0;
            arr_wr_idx_r  <= {IDXW{1'b0}};
            arr_wr_data_r <= 32'h0000_0000;
            fill_busy_r   <= 1'b0;
            line_done_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            ptr_r         <= ptr_next_s;
            rd_val_r      <= rd_hit_s;
            if (rd_hit_s) begin
                rd_data_r <= rd_data_next_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
            arr_wr_val_r  <= (state_next_s == DRAIN);
            arr_wr_idx_r  <= ptr_next_s;
            arr_wr_data_r <= arr_data_next_s;
            fill_busy_r   <= (state_next_s != IDLE);
            line_done_r   <= line_done_s;
        end
    end

    assign rdVal     = rd_val_r;
    assign rdData    = rd_data_r;
    assign arrWrVal  = arr_wr_val_r;
    assign arrWrIdx  = arr_wr_idx_r;
    assign arrWrData = arr_wr_data_r;
    assign fillBusy  = fill_busy_r;
    assign lineDone  = line_done_r;

endmodule
